hall_sequence_generator: RTL and testbench
==========================================

Name: hall_sequence_generator

Overview:
- Generates a six-step hall-sensor pattern from a commanded step period and direction; it drives the input side of the three-phase hall encoder.
- It serves as an on-chip hall emulator for sensorless/open-loop start-up and for loopback self-test of the encoder path.
- Outputs are registered hall_states_t values that are glitch-free: exactly one legal state change per step.

Parameters:
- counter_width, 32, width of the step-period timer, step_ticks and position.
- min_step_ticks, 2, smallest accepted non-zero step period; smaller non-zero requests are clamped up to this value.

Ports:
- clk  in  1  clock
- reset_n  in  1  asynchronous active-low reset
- enable  in  1  run request; low forces IDLE
- direction  in  rotation_direction_t  commanded direction: DIR_CW, DIR_CCW or DIR_NONE
- step_ticks  in  counter_width  requested clock cycles per hall step (per sector); 0 means stop
- load  in  1  one-cycle strobe that captures step_ticks and direction into the pending registers
- hall_values  out  hall_states_t  emulated hall pattern
- sector  out  3  sector index 0..5 matching hall_values
- step_strobe  out  1  one-cycle pulse in the cycle hall_values changes
- position  out  counter_width  signed-wrap step count: +1 per CW step, -1 per CCW step
- running  out  1  high while in the RUN state

Behaviour:
- Interface: one clock; reset is asynchronous and active-low (clk, reset_n).
- Reset values:
  - hall_values=HALL_AC, sector=0, step_strobe=0, position=0, running=0.
  - Pending period=0, pending direction=DIR_NONE, timer=0, state IDLE.
- Sector mapping is 0 HALL_AC, 1 HALL_A, 2 HALL_AB, 3 HALL_B, 4 HALL_BC, 5 HALL_C.
  - CW steps sector s -> (s+1) mod 6, which equals hall_states_t next().
  - CCW steps s -> (s+5) mod 6, which equals prev().
- load:
  - Captures step_ticks into the pending period and direction into the pending direction.
  - A captured non-zero period below min_step_ticks is stored as min_step_ticks.
  - load while IDLE takes effect immediately.
  - load while RUN takes effect at the next step boundary. The current step always completes with its old period and is never truncated or stretched.
- States:
  - IDLE:
    - hall_values, sector and position hold.
    - The timer is held at 0.
    - Transition to RUN when enable=1, pending direction != DIR_NONE and pending period != 0, all in the same cycle. running goes high in the following cycle.
  - RUN:
    - The active period and direction are copied from pending on entry and at every boundary.
    - The timer increments each cycle.
    - When timer == active period-1, the block steps in the next cycle: timer clears, sector/hall_values advance per active direction, position increments (CW) or decrements (CCW) with modulo 2^counter_width wrap, and step_strobe=1 for that single cycle.
    - The first step occurs exactly P cycles after the first RUN cycle.
  - RUN -> IDLE happens:
    - immediately, on the next clock, when enable=0: no step is taken and the timer clears;
    - at a boundary where pending direction == DIR_NONE or pending period == 0: the step in progress completes first, then the block stops without a further step.
- Direction reversal on load takes effect at the next boundary. That step moves opposite from the current sector; no skipped or repeated sector is allowed.
- Only legal sequences are ever output: hall_values never takes HALL values outside the six listed, and never changes by more than one sector per step.
- Simultaneous events:
  - load and boundary in the same cycle: the boundary uses the old pending values; the new values apply from the following boundary.
  - enable=0 and boundary in the same cycle: enable wins, no step.
- Reset asserted mid-operation returns all outputs to their reset values asynchronously. After release, the block restarts from HALL_AC in IDLE.
- step_strobe is never high in IDLE or in two consecutive cycles, even with min_step_ticks=1.

Test Plan:
1. Reset, then load step_ticks=10 with DIR_CW, enable=1 -> first step_strobe 10 cycles after running rises. hall_values runs HALL_A, HALL_AB, HALL_B, HALL_BC, HALL_C, HALL_AC, with strobes exactly 10 cycles apart; position=6 after six steps.
2. Run CW at 10; mid-step (timer=4) load step_ticks=20 with DIR_CCW -> the current step lands 6 cycles later, still CW. The next step comes 20 cycles later and is CCW, returning to the previous sector; position goes up by 1, then down by 1.
3. load step_ticks=1 -> period clamps to 2. Strobes arrive every 2 cycles and are never adjacent.
4. While RUN, drop enable with timer=P-2 -> the next cycle shows running=0 with no strobe, and hall_values holds. Re-enable -> the first step comes a full P cycles later.
5. Start with position at 0 and run CCW for 1 step -> position=all-ones (wraps) and hall_values=HALL_C.
6. Loopback into the three-phase hall encoder at step_ticks=100, pole_pairs=1, 27 MHz -> the encoder reports DIR_CW and rotation_duration 600 (700 for the first post-start measurement). Assert reset_n low mid-run -> hall_values=HALL_AC and position=0 with no clock edge required.

Source files
------------

// File: rtl/hall_sequence_generator_if.sv
`default_nettype none
// ============================================================================
// Module      : hall_sequence_generator_pkg / hall_sequence_generator_if
// Description : Shared hall/direction types and the command/pattern bundle
//               of the hall sequence generator.
// Revision    : 1.0 - initial release
// ============================================================================
package hall_sequence_generator_pkg;

    typedef enum logic [2:0] {
        HALL_C  = 3'b001,
        HALL_B  = 3'b010,
        HALL_BC = 3'b011,
        HALL_A  = 3'b100,
        HALL_AC = 3'b101,
        HALL_AB = 3'b110
    } hall_states_t;

    typedef enum logic [1:0] {
        DIR_NONE = 2'b00,
        DIR_CW   = 2'b01,
        DIR_CCW  = 2'b10
    } rotation_direction_t;

endpackage

interface hall_sequence_generator_if #(
    parameter int COUNTER_WIDTH = 32
);
    logic                                            enable;
    hall_sequence_generator_pkg::rotation_direction_t direction;
    logic [COUNTER_WIDTH-1:0]                        step_ticks;
    logic                                            load;
    hall_sequence_generator_pkg::hall_states_t       hall_values;
    logic [2:0]                                      sector;
    logic                                            step_strobe;
    logic [COUNTER_WIDTH-1:0]                        position;
    logic                                            running;

    modport master (
        output enable, direction, step_ticks, load,
        input  hall_values, sector, step_strobe, position, running
    );

    modport slave (
        input  enable, direction, step_ticks, load,
        output hall_values, sector, step_strobe, position, running
    );
endinterface
`default_nettype wire

// File: rtl/hall_sequence_generator.sv
`default_nettype none
// ============================================================================
// Module      : hall_sequence_generator
// Description : Six-step hall pattern emulator driven by a commanded step
//               period and direction, with glitch-free registered outputs.
// Revision    : 1.0 - initial release
// ============================================================================
module hall_sequence_generator
    import hall_sequence_generator_pkg::*;
#(
    parameter int COUNTER_WIDTH  = 32,
    parameter int MIN_STEP_TICKS = 2
) (
    input  wire logic                clk,
    input  wire logic                reset_n,
    hall_sequence_generator_if.slave bus
);

    localparam logic [0:0] c_IDLE = 1'b0;
    localparam logic [0:0] c_RUN  = 1'b1;

    // A period of 1 would strobe every cycle, so the floor never drops below 2.
    localparam int                       c_MIN_EFF   = (MIN_STEP_TICKS < 2) ? 2 : MIN_STEP_TICKS;
    localparam logic [COUNTER_WIDTH-1:0] c_MIN_TICKS = COUNTER_WIDTH'(c_MIN_EFF);
    localparam logic [COUNTER_WIDTH-1:0] c_ONE       = COUNTER_WIDTH'(1);

    logic [0:0]               r_state;
    logic [0:0]               w_state_next;
    logic [COUNTER_WIDTH-1:0] r_timer;
    logic [COUNTER_WIDTH-1:0] r_pend_period;
    logic [COUNTER_WIDTH-1:0] r_act_period;
    rotation_direction_t      r_pend_dir;
    rotation_direction_t      r_act_dir;
    logic [2:0]               r_sector;
    hall_states_t             r_hall;
    logic                     r_step_strobe;
    logic [COUNTER_WIDTH-1:0] r_position;

    logic                     w_pend_valid;
    logic                     w_boundary;
    logic                     w_step;
    logic                     w_take_pending;
    logic                     w_timer_clear;
    logic [COUNTER_WIDTH-1:0] w_load_period;
    rotation_direction_t      w_load_dir;
    logic [2:0]               w_sector_next;
    logic [COUNTER_WIDTH-1:0] w_position_next;

    function automatic hall_states_t sector_to_hall(input logic [2:0] s);
        case (s)
            3'd0:    sector_to_hall = HALL_AC;
            3'd1:    sector_to_hall = HALL_A;
            3'd2:    sector_to_hall = HALL_AB;
            3'd3:    sector_to_hall = HALL_B;
            3'd4:    sector_to_hall = HALL_BC;
            3'd5:    sector_to_hall = HALL_C;
            default: sector_to_hall = HALL_AC;
        endcase
    endfunction

    assign w_pend_valid  = (r_pend_dir != DIR_NONE) && (r_pend_period != '0);
    assign w_boundary    = (r_timer == (r_act_period - c_ONE));
    assign w_load_period = ((bus.step_ticks != '0) && (bus.step_ticks < c_MIN_TICKS))
                           ? c_MIN_TICKS : bus.step_ticks;
    assign w_load_dir    = ((bus.direction == DIR_CW) || (bus.direction == DIR_CCW))
                           ? bus.direction : DIR_NONE;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_IDLE: begin
                if (bus.enable && w_pend_valid) begin
                    w_state_next = c_RUN;
                end
            end
            c_RUN: begin
                if (!bus.enable) begin
                    w_state_next = c_IDLE;
                end else if (w_boundary && !w_pend_valid) begin
                    w_state_next = c_IDLE;
                end
            end
            default: w_state_next = c_IDLE;
        endcase
    end

    // Boundary both advances the pattern and re-arms from the old pending values.
    always_comb begin
        w_step         = 1'b0;
        w_take_pending = 1'b0;
        w_timer_clear  = 1'b1;
        case (r_state)
            c_IDLE: begin
                w_take_pending = bus.enable && w_pend_valid;
            end
            c_RUN: begin
                if (bus.enable) begin
                    w_step         = w_boundary;
                    w_take_pending = w_boundary;
                    w_timer_clear  = w_boundary;
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        w_sector_next   = r_sector;
        w_position_next = r_position;
        if (r_act_dir == DIR_CW) begin
            w_sector_next   = (r_sector == 3'd5) ? 3'd0 : r_sector + 3'd1;
            w_position_next = r_position + c_ONE;
        end else if (r_act_dir == DIR_CCW) begin
            w_sector_next   = (r_sector == 3'd0) ? 3'd5 : r_sector - 3'd1;
            w_position_next = r_position - c_ONE;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_timer       <= '0;
            r_pend_period <= '0;
            r_pend_dir    <= DIR_NONE;
            r_act_period  <= '0;
            r_act_dir     <= DIR_NONE;
            r_sector      <= 3'd0;
            r_hall        <= HALL_AC;
            r_step_strobe <= 1'b0;
            r_position    <= '0;
        end else begin
            r_timer       <= w_timer_clear ? '0 : r_timer + c_ONE;
            r_step_strobe <= w_step;
            if (bus.load) begin
                r_pend_period <= w_load_period;
                r_pend_dir    <= w_load_dir;
            end
            if (w_take_pending) begin
                r_act_period <= r_pend_period;
                r_act_dir    <= r_pend_dir;
            end
            if (w_step) begin
                r_sector   <= w_sector_next;
                r_hall     <= sector_to_hall(w_sector_next);
                r_position <= w_position_next;
            end
        end
    end

    assign bus.hall_values = r_hall;
    assign bus.sector      = r_sector;
    assign bus.step_strobe = r_step_strobe;
    assign bus.position    = r_position;
    assign bus.running     = (r_state == c_RUN);

endmodule
`default_nettype wire

// File: tb/tb_hall_sequence_generator.sv
`default_nettype none
// ============================================================================
// Module      : tb_hall_sequence_generator
// Description : Directed and randomized checks of hall_sequence_generator
//               against a countdown-based behavioural model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_hall_sequence_generator;
    import hall_sequence_generator_pkg::*;

    localparam int CW = 32;

    logic clk     = 1'b0;
    logic reset_n = 1'b1;
    bit   cmp_on  = 1'b0;
    int   n_checks = 0;
    int   n_errors = 0;

    hall_sequence_generator_if #(.COUNTER_WIDTH(CW)) bus ();

    hall_sequence_generator #(
        .COUNTER_WIDTH (CW),
        .MIN_STEP_TICKS(2)
    ) dut (
        .clk    (clk),
        .reset_n(reset_n),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    hall_states_t        ring [6] = '{HALL_AC, HALL_A, HALL_AB, HALL_B, HALL_BC, HALL_C};
    rotation_direction_t dirs [3] = '{DIR_NONE, DIR_CW, DIR_CCW};

    typedef struct {
        bit                  run;
        int                  sector;
        logic [CW-1:0]       pos;
        bit                  strobe;
        logic [CW-1:0]       pend_p;
        rotation_direction_t pend_d;
        logic [CW-1:0]       act_p;
        rotation_direction_t act_d;
        longint              left;
    } model_t;

    model_t m;

    function automatic model_t model_reset();
        model_t r;
        r.run = 0; r.sector = 0; r.pos = '0; r.strobe = 0;
        r.pend_p = '0; r.pend_d = DIR_NONE; r.act_p = '0; r.act_d = DIR_NONE; r.left = 0;
        return r;
    endfunction

    // Model counts cycles left in the current step rather than an up-timer.
    function automatic model_t model_next(model_t c, bit en, bit ld,
                                          logic [CW-1:0] ticks, rotation_direction_t d);
        model_t n;
        bit     valid;
        n        = c;
        n.strobe = 0;
        valid    = (c.pend_d == DIR_CW || c.pend_d == DIR_CCW) && (c.pend_p != 0);
        if (!c.run) begin
            if (en && valid) begin
                n.run = 1; n.act_p = c.pend_p; n.act_d = c.pend_d; n.left = longint'(c.pend_p);
            end
        end else if (!en) begin
            n.run = 0;
        end else if (c.left == 1) begin
            n.strobe = 1;
            if (c.act_d == DIR_CW) begin
                n.sector = (c.sector + 1) % 6;
                n.pos    = c.pos + CW'(1);
            end else begin
                n.sector = (c.sector + 5) % 6;
                n.pos    = c.pos - CW'(1);
            end
            if (valid) begin
                n.act_p = c.pend_p; n.act_d = c.pend_d; n.left = longint'(c.pend_p);
            end else begin
                n.run = 0;
            end
        end else begin
            n.left = c.left - 1;
        end
        if (ld) begin
            n.pend_p = (ticks != 0 && ticks < 2) ? CW'(2) : ticks;
            n.pend_d = (d == DIR_CW || d == DIR_CCW) ? d : DIR_NONE;
        end
        return n;
    endfunction

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) m <= model_reset();
        else          m <= model_next(m, bus.enable, bus.load, bus.step_ticks, bus.direction);
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (cmp_on && reset_n) begin
            check("model_hall",    bus.hall_values, ring[m.sector]);
            check("model_sector",  bus.sector, 64'(m.sector));
            check("model_strobe",  bus.step_strobe, m.strobe);
            check("model_pos",     bus.position, m.pos);
            check("model_running", bus.running, m.run);
        end
    end

    task automatic wait_strobe(input int max, output int cycles);
        cycles = 0;
        do begin
            @(negedge clk);
            cycles++;
        end while (!bus.step_strobe && cycles < max);
        check("strobe_seen", bus.step_strobe, 1);
    endtask

    task automatic wait_running(input int max);
        int c = 0;
        do begin
            @(negedge clk);
            c++;
        end while (!bus.running && c < max);
        check("running_seen", bus.running, 1);
    endtask

    task automatic load_cmd(input int ticks, input rotation_direction_t d);
        bus.load = 1; bus.step_ticks = CW'(ticks); bus.direction = d;
        @(negedge clk);
        bus.load = 0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset_n = 0;
        repeat (2) @(negedge clk);
        reset_n = 1;
    endtask

    initial begin
        hall_states_t exp1 [6] = '{HALL_A, HALL_AB, HALL_B, HALL_BC, HALL_C, HALL_AC};
        hall_states_t held;
        int c;

        bus.enable = 0; bus.load = 0; bus.step_ticks = '0; bus.direction = DIR_NONE;
        #1 reset_n = 0;
        repeat (3) @(negedge clk);
        reset_n = 1;
        cmp_on  = 1;
        check("rst_hall",    bus.hall_values, HALL_AC);
        check("rst_sector",  bus.sector, 0);
        check("rst_pos",     bus.position, 0);
        check("rst_running", bus.running, 0);
        check("rst_strobe",  bus.step_strobe, 0);

        // CW at period 10: full electrical revolution
        load_cmd(10, DIR_CW);
        bus.enable = 1;
        wait_running(5);
        wait_strobe(40, c);
        check("first_latency", c, 10);
        check("cw_hall0", bus.hall_values, exp1[0]);
        for (int k = 1; k < 6; k++) begin
            wait_strobe(40, c);
            check("cw_gap", c, 10);
            check("cw_hall", bus.hall_values, exp1[k]);
        end
        check("cw_pos6", bus.position, 6);

        // Reversal loaded mid-step at timer=4
        repeat (4) @(negedge clk);
        load_cmd(20, DIR_CCW);
        wait_strobe(40, c);
        check("rev_old_step", c + 1, 6);
        check("rev_cw_hall",  bus.hall_values, HALL_A);
        check("rev_cw_pos",   bus.position, 7);
        wait_strobe(60, c);
        check("rev_gap",      c, 20);
        check("rev_ccw_hall", bus.hall_values, HALL_AC);
        check("rev_ccw_pos",  bus.position, 6);

        // Clamp of period 1 up to 2
        load_cmd(1, DIR_CW);
        wait_strobe(40, c);
        wait_strobe(40, c);
        for (int k = 0; k < 5; k++) begin
            wait_strobe(10, c);
            check("clamp_gap", c, 2);
        end

        // enable drop at timer=P-2, then restart
        load_cmd(8, DIR_CW);
        wait_strobe(20, c);
        wait_strobe(20, c);
        check("p8_gap", c, 8);
        held = bus.hall_values;
        repeat (6) @(negedge clk);
        bus.enable = 0;
        @(negedge clk);
        check("drop_running", bus.running, 0);
        check("drop_strobe",  bus.step_strobe, 0);
        check("drop_hall",    bus.hall_values, held);
        repeat (3) @(negedge clk);
        check("idle_hall",    bus.hall_values, held);
        bus.enable = 1;
        @(negedge clk);
        check("reen_running", bus.running, 1);
        wait_strobe(20, c);
        check("reen_latency", c, 8);

        // CCW wrap from zero, then stop at the following boundary
        do_reset();
        check("rst2_pos", bus.position, 0);
        load_cmd(5, DIR_CCW);
        wait_running(5);
        wait_strobe(20, c);
        check("wrap_latency", c, 5);
        check("wrap_pos",  bus.position, 64'hFFFF_FFFF);
        check("wrap_hall", bus.hall_values, HALL_C);
        load_cmd(0, DIR_CCW);
        wait_strobe(20, c);
        check("stop_gap",     c + 1, 5);
        check("stop_running", bus.running, 0);
        check("stop_pos",     bus.position, 64'hFFFF_FFFE);
        check("stop_hall",    bus.hall_values, HALL_BC);
        repeat (3) @(negedge clk);
        check("stop_strobe",  bus.step_strobe, 0);

        // Asynchronous reset mid-run, observed before any clock edge
        load_cmd(3, DIR_CW);
        wait_running(5);
        wait_strobe(10, c);
        wait_strobe(10, c);
        #2 reset_n = 0;
        #1;
        check("arst_hall",    bus.hall_values, HALL_AC);
        check("arst_pos",     bus.position, 0);
        check("arst_running", bus.running, 0);
        check("arst_sector",  bus.sector, 0);
        @(negedge clk);
        reset_n = 1;

        // Randomized traffic checked against the model every cycle
        bus.enable = 1;
        for (int i = 0; i < 4000; i++) begin
            @(negedge clk);
            bus.load = 0;
            if (!reset_n) reset_n = 1;
            if ($urandom_range(0, 7) == 0) begin
                bus.load       = 1;
                bus.step_ticks = CW'($urandom_range(0, 9));
                bus.direction  = dirs[$urandom_range(0, 2)];
                if ($urandom_range(0, 3) != 0) bus.direction = dirs[$urandom_range(1, 2)];
            end
            if (bus.enable && $urandom_range(0, 39) == 0) bus.enable = 0;
            else if (!bus.enable && $urandom_range(0, 3) == 0) bus.enable = 1;
            if ($urandom_range(0, 999) == 0) reset_n = 0;
        end
        bus.load = 0;
        reset_n  = 1;
        repeat (3) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
